// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU control definitions: widths, exception and control-op codes,
// the trap vector, controller state encoding and event classes.
package pipe_ctrl_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int ISA_EXP_W   = 3;
  localparam int CTRL_OP_W   = 2;

  localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP     = 3'd0;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_EXT_INT    = 3'd1;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_UNDEF_INSN = 3'd2;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_OVERFLOW   = 3'd3;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_MISS_ALIGN = 3'd4;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_TRAP       = 3'd5;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_PRV_VIO    = 3'd6;

  localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP  = 2'd0;
  localparam logic [CTRL_OP_W-1:0] CTRL_OP_WRCR = 2'd1;
  localparam logic [CTRL_OP_W-1:0] CTRL_OP_ERET = 2'd2;
  localparam logic [CTRL_OP_W-1:0] CTRL_OP_HALT = 2'd3;

  localparam logic [WORD_ADDR_W-1:0] EXC_VECTOR = 30'h0000_0010;

  typedef enum logic {
    CPU_RUN  = 1'b0,
    CPU_HALT = 1'b1
  } cpu_state_t;

  // One event class per cycle, after priority resolution
  typedef enum logic [3:0] {
    EV_NONE,
    EV_BUSY,
    EV_EXC,
    EV_INT,
    EV_WAKE,
    EV_SLEEP,
    EV_ERET,
    EV_HALT,
    EV_BRANCH,
    EV_HAZARD
  } ev_t;

  // One bit per pipeline register
  typedef struct packed {
    logic if_r;
    logic id_r;
    logic ex_r;
    logic mem_r;
  } stage_t;

  localparam stage_t STG_NONE = '{if_r: 1'b0, id_r: 1'b0,
                                  ex_r: 1'b0, mem_r: 1'b0};
  localparam stage_t STG_ALL  = '{if_r: 1'b1, id_r: 1'b1,
                                  ex_r: 1'b1, mem_r: 1'b1};
  localparam stage_t STG_FRONT3 = '{if_r: 1'b1, id_r: 1'b1,
                                    ex_r: 1'b1, mem_r: 1'b0};
  localparam stage_t STG_FRONT2 = '{if_r: 1'b1, id_r: 1'b1,
                                    ex_r: 1'b0, mem_r: 1'b0};
  localparam stage_t STG_EX   = '{if_r: 1'b0, id_r: 1'b0,
                                  ex_r: 1'b1, mem_r: 1'b0};
  localparam stage_t STG_IF   = '{if_r: 1'b1, id_r: 1'b0,
                                  ex_r: 1'b0, mem_r: 1'b0};
  localparam stage_t STG_BACK3 = '{if_r: 1'b0, id_r: 1'b1,
                                   ex_r: 1'b1, mem_r: 1'b1};

  // Word address of the next sequential instruction, wrapping
  function automatic logic [WORD_ADDR_W-1:0] pc_inc(
    input logic [WORD_ADDR_W-1:0] pc
  );
    return pc + {{(WORD_ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: stalls, flushes, PC redirects
// and the EPC / cause / interrupt-enable / halt control state.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   IDLoadHazard,
  input  logic                   MemBusy,
  input  logic                   EXBrTaken,
  input  logic [WORD_ADDR_W-1:0] EXBrTarget,
  input  logic                   MEMEn,
  input  logic [WORD_ADDR_W-1:0] MEMPC,
  input  logic [ISA_EXP_W-1:0]   MEMExpCode,
  input  logic [CTRL_OP_W-1:0]   MEMCtrlOp,
  input  logic                   IRQ,
  output logic                   IFStall,
  output logic                   IDStall,
  output logic                   EXStall,
  output logic                   MEMStall,
  output logic                   IFFlush,
  output logic                   IDFlush,
  output logic                   EXFlush,
  output logic                   MEMFlush,
  output logic                   NewPCEn,
  output logic [WORD_ADDR_W-1:0] NewPC,
  output logic [WORD_ADDR_W-1:0] EPC,
  output logic [ISA_EXP_W-1:0]   ExpCodeReg,
  output logic                   IntEn,
  output logic                   Halted
);

  cpu_state_t state;
  cpu_state_t state_nxt;
  logic [WORD_ADDR_W-1:0] epc_nxt;
  logic [ISA_EXP_W-1:0]   code_nxt;
  logic                   ie_nxt;

  ev_t    ev;
  stage_t stall;
  stage_t flush;
  stage_t flush_q;

  logic exp_pend;
  logic int_pend;
  logic eret_req;
  logic halt_req;
  logic wake_req;

  assign exp_pend = MEMEn && (MEMExpCode != ISA_EXP_NO_EXP);
  assign int_pend = IRQ && IntEn && MEMEn;
  assign eret_req = MEMEn && (MEMCtrlOp == CTRL_OP_ERET);
  assign halt_req = MEMEn && (MEMCtrlOp == CTRL_OP_HALT);
  assign wake_req = IRQ && IntEn;

  // Resolve the single highest-priority event of this cycle
  always_comb begin
    ev = EV_NONE;
    if (reset_) begin
      ev = EV_NONE;
    end else if (MemBusy) begin
      ev = EV_BUSY;
    end else if (state == CPU_HALT) begin
      ev = wake_req ? EV_WAKE : EV_SLEEP;
    end else if (exp_pend) begin
      ev = EV_EXC;
    end else if (int_pend) begin
      ev = EV_INT;
    end else if (eret_req) begin
      ev = EV_ERET;
    end else if (halt_req) begin
      ev = EV_HALT;
    end else if (EXBrTaken) begin
      ev = EV_BRANCH;
    end else if (IDLoadHazard) begin
      ev = EV_HAZARD;
    end
  end

  // Map the resolved event onto stall, flush and redirect controls
  always_comb begin
    stall   = STG_NONE;
    flush   = STG_NONE;
    NewPCEn = 1'b0;
    NewPC   = '0;
    unique case (ev)
      EV_BUSY: begin
        stall = STG_ALL;
      end
      EV_EXC, EV_INT, EV_WAKE: begin
        flush   = STG_ALL;
        NewPCEn = 1'b1;
        NewPC   = EXC_VECTOR;
      end
      EV_SLEEP: begin
        stall = STG_IF;
        flush = STG_BACK3;
      end
      EV_ERET: begin
        flush   = STG_FRONT3;
        NewPCEn = 1'b1;
        NewPC   = EPC;
      end
      EV_HALT: begin
        flush = STG_FRONT3;
      end
      EV_BRANCH: begin
        flush   = STG_FRONT2;
        NewPCEn = 1'b1;
        NewPC   = EXBrTarget;
      end
      EV_HAZARD: begin
        stall = STG_FRONT2;
        flush = STG_EX;
      end
      default: begin
      end
    endcase
  end

  // A held register must never also be bubbled
  assign flush_q = flush & ~stall;

  assign IFStall  = stall.if_r;
  assign IDStall  = stall.id_r;
  assign EXStall  = stall.ex_r;
  assign MEMStall = stall.mem_r;
  assign IFFlush  = flush_q.if_r;
  assign IDFlush  = flush_q.id_r;
  assign EXFlush  = flush_q.ex_r;
  assign MEMFlush = flush_q.mem_r;
  assign Halted   = (state == CPU_HALT);

  // Next control state for traps, returns and halt/wake transitions
  always_comb begin
    state_nxt = state;
    epc_nxt   = EPC;
    code_nxt  = ExpCodeReg;
    ie_nxt    = IntEn;
    unique case (ev)
      EV_EXC: begin
        epc_nxt  = MEMPC;
        code_nxt = MEMExpCode;
        ie_nxt   = 1'b0;
      end
      EV_INT: begin
        epc_nxt  = MEMPC;
        code_nxt = ISA_EXP_EXT_INT;
        ie_nxt   = 1'b0;
      end
      EV_WAKE: begin
        state_nxt = CPU_RUN;
        code_nxt  = ISA_EXP_EXT_INT;
        ie_nxt    = 1'b0;
      end
      EV_ERET: begin
        ie_nxt = 1'b1;
      end
      EV_HALT: begin
        state_nxt = CPU_HALT;
        epc_nxt   = pc_inc(MEMPC);
      end
      default: begin
      end
    endcase
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state      <= CPU_RUN;
      EPC        <= '0;
      ExpCodeReg <= ISA_EXP_NO_EXP;
      IntEn      <= 1'b0;
    end else begin
      state      <= state_nxt;
      EPC        <= epc_nxt;
      ExpCodeReg <= code_nxt;
      IntEn      <= ie_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scenario bench for pipe_ctrl: each cycle's stimulus pushes its
// expected outputs, a monitor pops and compares mid-cycle.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic                   clk;
  logic                   reset_;
  logic                   IDLoadHazard;
  logic                   MemBusy;
  logic                   EXBrTaken;
  logic [WORD_ADDR_W-1:0] EXBrTarget;
  logic                   MEMEn;
  logic [WORD_ADDR_W-1:0] MEMPC;
  logic [ISA_EXP_W-1:0]   MEMExpCode;
  logic [CTRL_OP_W-1:0]   MEMCtrlOp;
  logic                   IRQ;
  logic                   IFStall, IDStall, EXStall, MEMStall;
  logic                   IFFlush, IDFlush, EXFlush, MEMFlush;
  logic                   NewPCEn;
  logic [WORD_ADDR_W-1:0] NewPC;
  logic [WORD_ADDR_W-1:0] EPC;
  logic [ISA_EXP_W-1:0]   ExpCodeReg;
  logic                   IntEn;
  logic                   Halted;

  typedef struct {
    logic                   rst;
    logic                   hz;
    logic                   busy;
    logic                   br;
    logic [WORD_ADDR_W-1:0] brt;
    logic                   men;
    logic [WORD_ADDR_W-1:0] mpc;
    logic [ISA_EXP_W-1:0]   code;
    logic [CTRL_OP_W-1:0]   op;
    logic                   irq;
  } in_t;

  typedef struct {
    logic [3:0]             st;
    logic [3:0]             fl;
    logic                   npe;
    logic [WORD_ADDR_W-1:0] npc;
    logic [WORD_ADDR_W-1:0] epc;
    logic [ISA_EXP_W-1:0]   code;
    logic                   ie;
    logic                   hl;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  localparam logic [WORD_ADDR_W-1:0] V = EXC_VECTOR;

  pipe_ctrl dut (
    .clk          (clk),
    .reset_       (reset_),
    .IDLoadHazard (IDLoadHazard),
    .MemBusy      (MemBusy),
    .EXBrTaken    (EXBrTaken),
    .EXBrTarget   (EXBrTarget),
    .MEMEn        (MEMEn),
    .MEMPC        (MEMPC),
    .MEMExpCode   (MEMExpCode),
    .MEMCtrlOp    (MEMCtrlOp),
    .IRQ          (IRQ),
    .IFStall      (IFStall),
    .IDStall      (IDStall),
    .EXStall      (EXStall),
    .MEMStall     (MEMStall),
    .IFFlush      (IFFlush),
    .IDFlush      (IDFlush),
    .EXFlush      (EXFlush),
    .MEMFlush     (MEMFlush),
    .NewPCEn      (NewPCEn),
    .NewPC        (NewPC),
    .EPC          (EPC),
    .ExpCodeReg   (ExpCodeReg),
    .IntEn        (IntEn),
    .Halted       (Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v.rst  = 1'b0;
    v.hz   = 1'b0;
    v.busy = 1'b0;
    v.br   = 1'b0;
    v.brt  = '0;
    v.men  = 1'b0;
    v.mpc  = '0;
    v.code = ISA_EXP_NO_EXP;
    v.op   = CTRL_OP_NOP;
    v.irq  = 1'b0;
    return v;
  endfunction

  function automatic exp_t E(
    input logic [3:0] st, input logic [3:0] fl,
    input logic npe, input logic [WORD_ADDR_W-1:0] npc,
    input logic [WORD_ADDR_W-1:0] epc, input logic [ISA_EXP_W-1:0] code,
    input logic ie, input logic hl);
    exp_t e;
    e.st = st; e.fl = fl; e.npe = npe; e.npc = npc;
    e.epc = epc; e.code = code; e.ie = ie; e.hl = hl;
    return e;
  endfunction

  task automatic cyc(input in_t v, input exp_t e);
    @(negedge clk);
    reset_       = v.rst;
    IDLoadHazard = v.hz;
    MemBusy      = v.busy;
    EXBrTaken    = v.br;
    EXBrTarget   = v.brt;
    MEMEn        = v.men;
    MEMPC        = v.mpc;
    MEMExpCode   = v.code;
    MEMCtrlOp    = v.op;
    IRQ          = v.irq;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    #2;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("stall", 32'({IFStall, IDStall, EXStall, MEMStall}), 32'(me.st));
      chk("flush", 32'({IFFlush, IDFlush, EXFlush, MEMFlush}), 32'(me.fl));
      chk("npcen", 32'(NewPCEn), 32'(me.npe));
      if (me.npe) chk("newpc", 32'(NewPC), 32'(me.npc));
      chk("epc", 32'(EPC), 32'(me.epc));
      chk("cause", 32'(ExpCodeReg), 32'(me.code));
      chk("inten", 32'(IntEn), 32'(me.ie));
      chk("halted", 32'(Halted), 32'(me.hl));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    in_t v;
    reset_ = 1'b1; IDLoadHazard = 0; MemBusy = 0; EXBrTaken = 0;
    EXBrTarget = '0; MEMEn = 0; MEMPC = '0; MEMExpCode = '0;
    MEMCtrlOp = '0; IRQ = 0;

    v = idle(); v.rst = 1; v.hz = 1; v.br = 1; v.brt = 30'h100;
    v.irq = 1; v.men = 1; v.code = ISA_EXP_OVERFLOW;
    cyc(v, E(4'b0000, 4'b0000, 0, '0, '0, ISA_EXP_NO_EXP, 0, 0));
    v = idle();
    cyc(v, E(4'b0000, 4'b0000, 0, '0, '0, ISA_EXP_NO_EXP, 0, 0));
    v = idle(); v.hz = 1;
    cyc(v, E(4'b1100, 4'b0010, 0, '0, '0, ISA_EXP_NO_EXP, 0, 0));
    cyc(v, E(4'b1100, 4'b0010, 0, '0, '0, ISA_EXP_NO_EXP, 0, 0));
    v = idle();
    cyc(v, E(4'b0000, 4'b0000, 0, '0, '0, ISA_EXP_NO_EXP, 0, 0));
    v = idle(); v.br = 1; v.brt = 30'h100;
    cyc(v, E(4'b0000, 4'b1100, 1, 30'h100, '0, ISA_EXP_NO_EXP, 0, 0));
    v = idle(); v.men = 1; v.mpc = 30'h40; v.code = ISA_EXP_OVERFLOW;
    v.irq = 1;
    cyc(v, E(4'b0000, 4'b1111, 1, V, '0, ISA_EXP_NO_EXP, 0, 0));
    v = idle();
    cyc(v, E(4'b0000, 4'b0000, 0, '0, 30'h40, ISA_EXP_OVERFLOW, 0, 0));
    v = idle(); v.men = 1; v.mpc = 30'h55; v.op = CTRL_OP_ERET;
    cyc(v, E(4'b0000, 4'b1110, 1, 30'h40, 30'h40, ISA_EXP_OVERFLOW, 0, 0));
    v = idle();
    cyc(v, E(4'b0000, 4'b0000, 0, '0, 30'h40, ISA_EXP_OVERFLOW, 1, 0));
    v = idle(); v.men = 1; v.mpc = 30'h20; v.code = ISA_EXP_UNDEF_INSN;
    v.irq = 1;
    cyc(v, E(4'b0000, 4'b1111, 1, V, 30'h40, ISA_EXP_OVERFLOW, 1, 0));
    v = idle();
    cyc(v, E(4'b0000, 4'b0000, 0, '0, 30'h20, ISA_EXP_UNDEF_INSN, 0, 0));
    v = idle(); v.men = 1; v.op = CTRL_OP_ERET;
    cyc(v, E(4'b0000, 4'b1110, 1, 30'h20, 30'h20, ISA_EXP_UNDEF_INSN, 0, 0));
    v = idle(); v.irq = 1;
    cyc(v, E(4'b0000, 4'b0000, 0, '0, 30'h20, ISA_EXP_UNDEF_INSN, 1, 0));
    v = idle(); v.men = 1; v.mpc = 30'h7F; v.op = CTRL_OP_HALT;
    cyc(v, E(4'b0000, 4'b1110, 0, '0, 30'h20, ISA_EXP_UNDEF_INSN, 1, 0));
    v = idle();
    cyc(v, E(4'b1000, 4'b0111, 0, '0, 30'h80, ISA_EXP_UNDEF_INSN, 1, 1));
    v = idle(); v.br = 1; v.brt = 30'h300;
    cyc(v, E(4'b1000, 4'b0111, 0, '0, 30'h80, ISA_EXP_UNDEF_INSN, 1, 1));
    v = idle(); v.irq = 1;
    cyc(v, E(4'b0000, 4'b1111, 1, V, 30'h80, ISA_EXP_UNDEF_INSN, 1, 1));
    v = idle();
    cyc(v, E(4'b0000, 4'b0000, 0, '0, 30'h80, ISA_EXP_EXT_INT, 0, 0));
    v = idle(); v.men = 1; v.mpc = 30'h11; v.op = CTRL_OP_ERET;
    cyc(v, E(4'b0000, 4'b1110, 1, 30'h80, 30'h80, ISA_EXP_EXT_INT, 0, 0));
    v = idle();
    cyc(v, E(4'b0000, 4'b0000, 0, '0, 30'h80, ISA_EXP_EXT_INT, 1, 0));
    v = idle(); v.men = 1; v.mpc = 30'h44; v.irq = 1;
    cyc(v, E(4'b0000, 4'b1111, 1, V, 30'h80, ISA_EXP_EXT_INT, 1, 0));
    v = idle();
    cyc(v, E(4'b0000, 4'b0000, 0, '0, 30'h44, ISA_EXP_EXT_INT, 0, 0));
    v = idle(); v.busy = 1; v.br = 1; v.brt = 30'h200; v.men = 1;
    v.mpc = 30'h60; v.code = ISA_EXP_TRAP;
    cyc(v, E(4'b1111, 4'b0000, 0, '0, 30'h44, ISA_EXP_EXT_INT, 0, 0));
    cyc(v, E(4'b1111, 4'b0000, 0, '0, 30'h44, ISA_EXP_EXT_INT, 0, 0));
    v.busy = 0;
    cyc(v, E(4'b0000, 4'b1111, 1, V, 30'h44, ISA_EXP_EXT_INT, 0, 0));
    v = idle(); v.br = 1; v.brt = 30'h200; v.hz = 1;
    cyc(v, E(4'b0000, 4'b1100, 1, 30'h200, 30'h60, ISA_EXP_TRAP, 0, 0));
    v.men = 1; v.mpc = 30'h61; v.op = CTRL_OP_ERET;
    cyc(v, E(4'b0000, 4'b1110, 1, 30'h60, 30'h60, ISA_EXP_TRAP, 0, 0));
    v.mpc = 30'h3FFF_FFFF; v.op = CTRL_OP_HALT;
    cyc(v, E(4'b0000, 4'b1110, 0, '0, 30'h60, ISA_EXP_TRAP, 1, 0));
    v = idle();
    cyc(v, E(4'b1000, 4'b0111, 0, '0, 30'h0, ISA_EXP_TRAP, 1, 1));
    v = idle(); v.rst = 1; v.irq = 1; v.men = 1; v.code = ISA_EXP_TRAP;
    cyc(v, E(4'b0000, 4'b0000, 0, '0, '0, ISA_EXP_NO_EXP, 0, 0));
    v = idle(); v.irq = 1; v.men = 1; v.mpc = 30'h9;
    cyc(v, E(4'b0000, 4'b0000, 0, '0, '0, ISA_EXP_NO_EXP, 0, 0));

    @(negedge clk);
    #5;
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
